// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the 32-bit hex value from a scanned 8-digit 7-segment bus.
// Optional decimal-point capture is enabled with SCAN_DP_CAPTURE_EN.
module seg_scan_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Anode,
  input  logic [6:0]  cathode,
`ifdef SCAN_DP_CAPTURE_EN
  input  logic        dp,
  output logic [7:0]  dp_out,
`endif
  input  logic        clr_err,
  output logic [31:0] value,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        pat_err,
  output logic        anode_err
);
`ifdef SCAN_DP_CAPTURE_EN
  localparam int CW = 16;
  logic [CW-1:0] bus;
  logic [7:0]    sdp_q, sdp_d;
  assign bus = {dp, Anode, cathode};
`else
  localparam int CW = 15;
  logic [CW-1:0] bus;
  assign bus = {Anode, cathode};
`endif
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    cand_an, last_q, mask_q, mask_new, sblank_q, sblank_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          last_valid_q;
  logic          an_valid, an_off, an_multi, same, same_an, settled, move, load, cap, done;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic          blk, bad, seq_ev, pat_ev, an_ev;

  function automatic logic [5:0] decode(input logic [6:0] c);
    case (c)
      7'h01: decode = 6'h00;
      7'h4F: decode = 6'h01;
      7'h12: decode = 6'h02;
      7'h06: decode = 6'h03;
      7'h4C: decode = 6'h04;
      7'h24: decode = 6'h05;
      7'h20: decode = 6'h06;
      7'h0F: decode = 6'h07;
      7'h00: decode = 6'h08;
      7'h04: decode = 6'h09;
      7'h08: decode = 6'h0A;
      7'h60: decode = 6'h0B;
      7'h31: decode = 6'h0C;
      7'h42: decode = 6'h0D;
      7'h30: decode = 6'h0E;
      7'h38: decode = 6'h0F;
      7'h7F: decode = 6'h10;
      default: decode = 6'h20;
    endcase
  endfunction

  assign cand_an  = cand_q[14:7];
  assign an_valid = $countones(~Anode) == 1;
  assign an_off   = &Anode;
  assign an_multi = !an_valid && !an_off;
  assign same     = bus == cand_q;
  assign same_an  = Anode == cand_an;
  assign settled  = cnt_q >= 4'(SETTLE - 1);
  assign cap      = state_q == S_CAPTURE;
  assign {bad, blk, nib} = decode(cand_q[6:0]);
  assign mask_new = mask_q | ~cand_an;
  assign done     = cap && (&mask_new);

  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = an_valid ? S_SETTLE : S_IDLE;
      S_SETTLE:  state_d = same ? (settled ? S_CAPTURE : S_SETTLE) : (an_valid ? S_SETTLE : S_IDLE);
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD:    state_d = same_an ? S_HOLD : (an_valid ? S_SETTLE : S_IDLE);
      default:   state_d = S_IDLE;
    endcase
  end

  // The bus is re-evaluated as a fresh candidate whenever the current one is abandoned.
  always_comb begin
    move = (state_q == S_IDLE) || (state_q == S_SETTLE && !same) || (state_q == S_HOLD && !same_an);
    load = move && an_valid;
    an_ev = move && an_multi;
    cand_d = load ? bus : cand_q;
    cnt_d = load ? 4'd1 : (state_q == S_SETTLE && same) ? cnt_q + 4'd1 : cnt_q;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) if (!cand_an[i]) idx = 3'(i);
    seq_ev = cap && last_valid_q && (cand_an != {last_q[6:0], last_q[7]});
    pat_ev = cap && bad;
    shadow_d = shadow_q;
    sblank_d = sblank_q;
    if (cap) begin
      shadow_d[{idx, 2'b00} +: 4] = nib;
      sblank_d[idx] = blk;
    end
`ifdef SCAN_DP_CAPTURE_EN
    sdp_d = sdp_q;
    if (cap) sdp_d[idx] = !cand_q[15];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      sblank_q     <= '0;
      mask_q       <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      value        <= '0;
      blank        <= '0;
      frame_valid  <= 1'b0;
      seq_err      <= 1'b0;
      pat_err      <= 1'b0;
      anode_err    <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      sblank_q     <= sblank_d;
      mask_q       <= cap ? (done ? 8'h00 : mask_new) : mask_q;
      last_q       <= cap ? cand_an : last_q;
      last_valid_q <= last_valid_q || cap;
      value        <= done ? shadow_d : value;
      blank        <= done ? sblank_d : blank;
      frame_valid  <= done;
      seq_err      <= (seq_err && !clr_err) || seq_ev;
      pat_err      <= (pat_err && !clr_err) || pat_ev;
      anode_err    <= (anode_err && !clr_err) || an_ev;
    end
  end

`ifdef SCAN_DP_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sdp_q  <= '0;
      dp_out <= '0;
    end else begin
      sdp_q  <= sdp_d;
      dp_out <= done ? sdp_d : dp_out;
    end
  end
`endif
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the 8-digit anode scan driver. Watches the multiplexed anode/cathode bus of the 7-segment display and rebuilds the 32-bit hex value being shown.
- Used as a loopback checker and readback path: its output can be compared against the value the display logic was asked to show.
- Samples each digit only after the bus has been stable for a settle time. Publishes a full 8-digit frame once every digit has been captured.

Parameters:
- SETTLE, 4, consecutive stable clk cycles needed before a digit is sampled (range 1..15; 4-bit counter).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- Anode  input  8  scanned anode bus, active low, one-hot-low when valid (8'hFE = digit 0 ... 8'h7F = digit 7)
- cathode  input  7  segments {a,b,c,d,e,f,g}, active low, bit 6 = a
- clr_err  input  1  single-cycle clear of the sticky error flags
- value  output  32  last complete frame; digit n occupies bits [4n+3:4n]
- blank  output  8  last complete frame; bit n = 1 if digit n was all segments off (7'h7F)
- frame_valid  output  1  one-cycle pulse when value/blank update
- seq_err  output  1  sticky: anode rotation out of order
- pat_err  output  1  sticky: unrecognised cathode pattern
- anode_err  output  1  sticky: multi-hot anode seen

Behaviour:
- Reset: all outputs 0; internal shadow, capture mask and last-anode register cleared; FSM to IDLE.
- Anode classification each cycle:
  - valid = exactly one bit low;
  - off = 8'hFF;
  - multi = any other value.
- Decode table (cathode -> nibble):
  - 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7,
  - 00->8, 04->9, 08->A, 60->b, 31->C, 42->d, 30->E, 38->F.
  - 7F -> nibble 0 with the blank bit set.
  - Any other pattern -> nibble 0, blank bit 0, pat_err set.
- FSM:
  - IDLE: valid anode -> SETTLE with cnt=1 and cand latched = (Anode, cathode). multi -> set anode_err, stay in IDLE. off -> stay in IDLE.
  - SETTLE: if (Anode, cathode) equals cand, cnt increments; when cnt reaches SETTLE -> CAPTURE. If they differ: re-enter SETTLE with the new value if it is valid, otherwise go to IDLE (setting anode_err if multi).
  - CAPTURE (one cycle): perform the capture steps below, then -> HOLD.
  - HOLD: wait while Anode == cand. On any change: valid -> SETTLE with the new candidate; off/multi -> IDLE (anode_err if multi).
- Capture steps (in CAPTURE):
  - Write the decoded nibble and blank bit into the shadow at the digit index.
  - Set mask bit n.
  - Rotation check: if last_valid and cand != rotate-left-by-one(last_anode) with 8'h7F -> 8'hFE wrap, set seq_err. Then last_anode <= cand, last_valid <= 1.
- Re-capturing the same digit: overwrites its shadow nibble; mask is unchanged.
- Frame completion:
  - Condition: the capture cycle makes the mask 8'hFF.
  - Effect, in that same cycle: value/blank <= shadow including the new nibble, frame_valid = 1 on the next clock edge (registered), mask <= 0.
  - Latency: frame_valid is asserted 1 cycle after the CAPTURE cycle of the 8th distinct digit.
- Error flags:
  - Sticky until clr_err or rst.
  - If clr_err and a new error event coincide, the flag ends the cycle set (set wins).
- rst mid-frame: partial mask and shadow are discarded; value keeps no stale data (cleared to 0).
- Capture and error flags depend only on the sequence of distinct stable anodes, not on scan speed.

Optional Feature:
- Macro: SCAN_DP_CAPTURE_EN.
- Defined:
  - Adds input dp (1 bit, active low) and output dp_out (8 bits).
  - dp is included in the stability compare and captured per digit.
  - dp_out updates with value on frame completion, bit n = 1 when the dot is lit.
- Undefined: no dp port, no dp_out port; the stability compare uses Anode and cathode only.

Test Plan:
- Clean scan, SETTLE=4: drive 8'hFE..8'h7F in order, each digit held 10 cycles, with cathodes encoding 1,2,3,4,5,6,7,8 (digit 0 = 1). Expect:
  - one frame_valid pulse;
  - value = 32'h87654321, blank = 8'h00;
  - all error flags 0.
- Settle filter: glitch cathode for 2 cycles before a stable 7'h30 on 8'hFB. Expect:
  - no capture of the glitch value;
  - digit 2 = E after 4 stable cycles;
  - pat_err stays 0 if the glitch lasted under SETTLE cycles.
- Ghost gaps and blank: insert 8'hFF for 3 cycles between digits and show 7'h7F on 8'h7F. Expect:
  - frame completes normally;
  - blank = 8'h80, digit 7 nibble = 0;
  - seq_err = 0.
- Order violation: scan FE, FD, F7 (skipping FB). Expect:
  - seq_err = 1 after the F7 capture;
  - no frame_valid until FB is also captured;
  - clr_err clears seq_err.
- Bad inputs: hold Anode = 8'hFC for 5 cycles, then a stable cathode 7'h55 on 8'hFE. Expect:
  - anode_err = 1;
  - pat_err = 1 and digit 0 = 0 in the next frame.
- Reset mid-frame: capture 5 digits, pulse rst, then complete a full scan. Expect:
  - frame_valid only after 8 fresh captures;
  - value matches the post-reset digits only.
